tv_sequencer: RTL and testbench

//  Synthesizable, parametrised test-vector sequencer/checker for on-chip self-test of combinational DUTs.

---
 rtl/tv_seq_if.sv | 34 +++
 rtl/tv_sequencer.sv | 131 +++++++++++++
 tb/tb_tv_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tv_seq_if.sv
// Bundle of the load, run-control, DUT-facing and status signals of tv_sequencer.
// The slave modport is the sequencer; master is the environment (loader, controller, DUT).
interface tv_seq_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1,
  parameter int DEPTH = 16,
  parameter int CW    = 8
);
  localparam int AW = $clog2(DEPTH);
  localparam int VW = N_IN + 2 * N_OUT;

  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [VW-1:0] ld_data;
  logic          start;
  logic [AW:0]   num_vec;
  logic [N_IN-1:0]  dut_in;
  logic [N_OUT-1:0] dut_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] err_cnt;
  logic [AW-1:0] first_fail;
  logic          fail_pulse;

  modport master (
    output ld_en, ld_addr, ld_data, start, num_vec, dut_out,
    input  dut_in, busy, done, err_cnt, first_fail, fail_pulse
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, start, num_vec, dut_out,
    output dut_in, busy, done, err_cnt, first_fail, fail_pulse
  );
endinterface

// File: rtl/tv_sequencer.sv
// Test-vector sequencer/checker: replays {in, exp, mask} words onto a combinational DUT,
// waits SETTLE cycles, compares masked outputs and keeps a saturating mismatch count.
module tv_sequencer #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int DEPTH  = 16,
  parameter int SETTLE = 1,
  parameter int CW     = 8
) (
  input  logic     clk,
  input  logic     reset,
  tv_seq_if.slave  bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int VW  = N_IN + 2 * N_OUT;
  localparam int SCW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SCW-1:0] SETTLE_V = SCW'(SETTLE);
  localparam logic [AW:0]    DEPTH_V  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_APPLY, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  logic [VW-1:0]    mem [DEPTH];
  logic [VW-1:0]    rd_word_p1;
  logic [N_OUT-1:0] exp_p2;
  logic [N_OUT-1:0] mask_p2;

  state_t           state;
  logic [AW-1:0]    idx;
  logic [AW:0]      nv_q;
  logic [SCW-1:0]   settle_cnt;
  logic [N_IN-1:0]  dut_in_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    err_q;
  logic [AW-1:0]    first_fail_q;

  logic idle_like;
  logic mismatch;
  logic last_vec;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [AW:0] clamp_nv(input logic [AW:0] n);
    return (n > DEPTH_V) ? DEPTH_V : n;
  endfunction

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign mismatch  = |((bus.dut_out ^ exp_p2) & mask_p2);
  assign last_vec  = ({1'b0, idx} == (nv_q - 1'b1));

  // stage p1: memory read of mem[idx] lands in APPLY; stage p2: expected/mask held for CHECK
  always_ff @(posedge clk) begin
    if (bus.ld_en && idle_like) mem[bus.ld_addr] <= bus.ld_data;
    rd_word_p1 <= mem[idx];
    if (state == S_APPLY) begin
      exp_p2  <= rd_word_p1[2*N_OUT-1 -: N_OUT];
      mask_p2 <= rd_word_p1[N_OUT-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      nv_q         <= '0;
      settle_cnt   <= '0;
      dut_in_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= '0;
      first_fail_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            err_q        <= '0;
            first_fail_q <= '0;
            idx          <= '0;
            nv_q         <= clamp_nv(bus.num_vec);
            if (bus.num_vec == '0) begin
              state  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state  <= S_FETCH;
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end
          end
        end
        S_FETCH: state <= S_APPLY;
        S_APPLY: begin
          dut_in_q   <= rd_word_p1[VW-1 -: N_IN];
          settle_cnt <= SETTLE_V;
          state      <= (SETTLE > 0) ? S_SETTLE : S_CHECK;
        end
        S_SETTLE: begin
          if (settle_cnt == SCW'(1)) state <= S_CHECK;
          else settle_cnt <= settle_cnt - 1'b1;
        end
        S_CHECK: begin
          if (mismatch) begin
            err_q <= sat_inc(err_q);
            if (err_q == '0) first_fail_q <= idx;
          end
          if (last_vec) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // fail_pulse must coincide with the CHECK cycle itself, so it is decoded, not registered
  assign bus.fail_pulse = (state == S_CHECK) && mismatch;
  assign bus.dut_in     = dut_in_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err_cnt    = err_q;
  assign bus.first_fail = first_fail_q;
endmodule

// File: tb/tb_tv_sequencer.sv
// Bench for tv_sequencer: two instances (SETTLE=1/CW=8 and SETTLE=0/CW=2) against a
// timeline model derived from the per-vector cost, plus directed literal expectations.
module tb_tv_sequencer;
  localparam int N_IN = 3, N_OUT = 1, DEPTH = 16, AW = 4, VW = 5;
  localparam int S_A = 1, S_B = 0, CW_A = 8, CW_B = 2;

  logic clk = 1'b0;
  logic reset;
  logic ld_en, start;
  logic [AW-1:0] ld_addr;
  logic [VW-1:0] ld_data;
  logic [AW:0]   num_vec;
  int mode;  // 0 correct DUT, 1 stuck at 0, 2 inverted

  int checks = 0, errors = 0;
  int pulses_a = 0, pulses_b = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic truth(input logic [2:0] v);
    return (~v[1] & ~v[0]) | (v[2] & ~v[1]);
  endfunction

  function automatic logic dut_fn(input logic [2:0] v, input int md);
    case (md)
      0: return truth(v);
      1: return 1'b0;
      default: return ~truth(v);
    endcase
  endfunction

  tv_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH), .CW(CW_A)) ifa ();
  tv_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH), .CW(CW_B)) ifb ();

  assign ifa.ld_en = ld_en;   assign ifb.ld_en = ld_en;
  assign ifa.ld_addr = ld_addr; assign ifb.ld_addr = ld_addr;
  assign ifa.ld_data = ld_data; assign ifb.ld_data = ld_data;
  assign ifa.start = start;   assign ifb.start = start;
  assign ifa.num_vec = num_vec; assign ifb.num_vec = num_vec;
  assign ifa.dut_out = dut_fn(ifa.dut_in, mode);
  assign ifb.dut_out = dut_fn(ifb.dut_in, mode);

  tv_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH), .SETTLE(S_A), .CW(CW_A))
    u_a (.clk(clk), .reset(reset), .bus(ifa));
  tv_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH), .SETTLE(S_B), .CW(CW_B))
    u_b (.clk(clk), .reset(reset), .bus(ifb));

  // ---------------- reference model: run timeline by arithmetic ----------------
  logic [VW-1:0] m_mem [2][DEPTH];
  logic [VW-1:0] m_vec [2][DEPTH];
  int m_t [2], m_n [2], m_mode [2];
  bit m_run [2];
  logic [2:0] m_base [2];

  function automatic int sett(input int i); return (i == 0) ? S_A : S_B; endfunction
  function automatic int per(input int i); return sett(i) + 3; endfunction
  function automatic int maxc(input int i); return (i == 0) ? 255 : 3; endfunction

  function automatic bit mis(input int i, input int k);
    logic [VW-1:0] w;
    w = m_vec[i][k];
    return ((dut_fn(w[4:2], m_mode[i]) ^ w[1]) & w[0]) == 1'b1;
  endfunction

  function automatic bit e_busy(input int i);
    return m_run[i] && (m_t[i] < m_n[i] * per(i));
  endfunction

  function automatic bit e_done(input int i);
    return m_run[i] && !(m_t[i] < m_n[i] * per(i));
  endfunction

  function automatic logic [2:0] e_in(input int i);
    int a;
    a = 0;
    if (m_run[i] && m_t[i] >= 2) a = (m_t[i] - 2) / per(i) + 1;
    if (a > m_n[i]) a = m_n[i];
    return (a > 0) ? m_vec[i][a-1][4:2] : m_base[i];
  endfunction

  function automatic int n_checked(input int i);
    int c;
    if (!m_run[i] || m_t[i] < sett(i) + 3) return 0;
    c = (m_t[i] - sett(i) - 3) / per(i) + 1;
    return (c > m_n[i]) ? m_n[i] : c;
  endfunction

  function automatic int e_err(input int i);
    int s;
    s = 0;
    for (int k = 0; k < n_checked(i); k++) if (mis(i, k)) s++;
    return (s > maxc(i)) ? maxc(i) : s;
  endfunction

  function automatic int e_ff(input int i);
    for (int k = 0; k < n_checked(i); k++) if (mis(i, k)) return k;
    return 0;
  endfunction

  function automatic bit e_pulse(input int i);
    return e_busy(i) && (m_t[i] % per(i) == sett(i) + 2) && mis(i, m_t[i] / per(i));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_run[i]  <= 1'b0;
        m_t[i]    <= 0;
        m_n[i]    <= 0;
        m_base[i] <= '0;
      end else begin
        if (ld_en && !e_busy(i)) m_mem[i][ld_addr] <= ld_data;
        if (start && !e_busy(i)) begin
          m_base[i] <= e_in(i);
          for (int k = 0; k < DEPTH; k++)
            m_vec[i][k] <= (ld_en && int'(ld_addr) == k) ? ld_data : m_mem[i][k];
          m_mode[i] <= mode;
          m_n[i]    <= (int'(num_vec) > DEPTH) ? DEPTH : int'(num_vec);
          m_t[i]    <= 0;
          m_run[i]  <= 1'b1;
        end else if (e_busy(i)) begin
          m_t[i] <= m_t[i] + 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [2:0] din, input logic bsy, input logic dn,
                          input logic [7:0] ec, input logic [3:0] ff, input logic fp);
    string p;
    p = (i == 0) ? "A" : "B";
    chk({p, "_dut_in"}, 32'(din), 32'(e_in(i)));
    chk({p, "_busy"}, 32'(bsy), 32'(e_busy(i)));
    chk({p, "_done"}, 32'(dn), 32'(e_done(i)));
    chk({p, "_err_cnt"}, 32'(ec), 32'(e_err(i)));
    chk({p, "_first_fail"}, 32'(ff), 32'(e_ff(i)));
    chk({p, "_fail_pulse"}, 32'(fp), 32'(e_pulse(i)));
  endtask

  task automatic compare_all();
    if (ifa.fail_pulse === 1'b1) pulses_a++;
    if (ifb.fail_pulse === 1'b1) pulses_b++;
    if (!chk_en) return;
    cmp_inst(0, ifa.dut_in, ifa.busy, ifa.done, ifa.err_cnt, ifa.first_fail, ifa.fail_pulse);
    cmp_inst(1, ifb.dut_in, ifb.busy, ifb.done, {6'd0, ifb.err_cnt}, ifb.first_fail,
             ifb.fail_pulse);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    #2;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [VW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic start_run(input int n);
    start = 1'b1; num_vec = (AW + 1)'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_a(output int lat);
    lat = 0;
    while (ifa.done !== 1'b1 && lat < 400) begin tick(); lat++; end
  endtask

  task automatic wait_both();
    int n;
    n = 0;
    while (!(ifa.done === 1'b1 && ifb.done === 1'b1) && n < 400) begin tick(); n++; end
    chk("wait_done_bound", 32'(n < 400), 32'd1);
  endtask

  task automatic load_truth(input logic msk);
    for (int v = 0; v < 8; v++) begin
      logic [2:0] v3;
      v3 = 3'(v);
      load(4'(v), {v3, truth(v3), msk});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, pa0, pb0, nv, act, k;
    reset = 1'b1; ld_en = 1'b0; start = 1'b0; ld_addr = '0; ld_data = '0; num_vec = '0;
    mode = 0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    chk("reset_busy", 32'(ifa.busy), 32'd0);
    chk("reset_done", 32'(ifa.done), 32'd0);
    chk("reset_err_cnt", 32'(ifa.err_cnt), 32'd0);
    chk("reset_dut_in", 32'(ifa.dut_in), 32'd0);
    reset = 1'b0;
    tick();

    for (int a = 0; a < DEPTH; a++) load(4'(a), 5'($urandom));
    load_truth(1'b1);

    // T1: correct DUT
    mode = 0; pa0 = pulses_a;
    start_run(8); wait_a(lat); wait_both();
    chk("T1_latency", 32'(lat), 32'd32);
    chk("T1_err_cnt", 32'(ifa.err_cnt), 32'd0);
    chk("T1_pulses", 32'(pulses_a - pa0), 32'd0);

    // T2: stuck at 0
    mode = 1; pa0 = pulses_a;
    start_run(8); wait_a(lat); wait_both();
    chk("T2_err_cnt", 32'(ifa.err_cnt), 32'd3);
    chk("T2_first_fail", 32'(ifa.first_fail), 32'd0);
    chk("T2_pulses", 32'(pulses_a - pa0), 32'd3);

    // T3: all masks off
    load_truth(1'b0);
    start_run(8); wait_a(lat); wait_both();
    chk("T3_err_cnt", 32'(ifa.err_cnt), 32'd0);
    chk("T3_done", 32'(ifa.done), 32'd1);

    // T4: empty run
    start_run(0);
    chk("T4_done", 32'(ifa.done), 32'd1);
    chk("T4_busy", 32'(ifa.busy), 32'd0);
    chk("T4_err_cnt", 32'(ifa.err_cnt), 32'd0);
    tick(); tick();

    // T5: inverted DUT, saturation on the CW=2 instance
    load_truth(1'b1);
    mode = 2; pb0 = pulses_b;
    start_run(8); wait_a(lat); wait_both();
    chk("T5_sat_err_cnt", 32'(ifb.err_cnt), 32'd3);
    chk("T5_sat_first_fail", 32'(ifb.first_fail), 32'd0);
    chk("T5_sat_pulses", 32'(pulses_b - pb0), 32'd8);
    chk("T5_wide_err_cnt", 32'(ifa.err_cnt), 32'd8);

    // T6: reset during vector 4, then rerun with an ignored mid-run start
    mode = 0;
    start_run(8);
    repeat (17) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("T6_reset_busy", 32'(ifa.busy), 32'd0);
    chk("T6_reset_done", 32'(ifa.done), 32'd0);
    chk("T6_reset_err_cnt", 32'(ifa.err_cnt), 32'd0);
    chk("T6_reset_dut_in", 32'(ifa.dut_in), 32'd0);
    start_run(8);
    lat = 0;
    while (ifa.done !== 1'b1 && lat < 400) begin
      if (lat == 5) begin start = 1'b1; num_vec = 5'd3; end
      tick(); lat++;
      start = 1'b0;
    end
    wait_both();
    chk("T6_latency", 32'(lat), 32'd32);
    chk("T6_err_cnt", 32'(ifa.err_cnt), 32'd0);

    // randomized runs
    for (int r = 0; r < 30; r++) begin
      mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 4)) load(4'($urandom), 5'($urandom));
      nv = $urandom_range(0, 24);
      ld_en = 1'($urandom); ld_addr = '0; ld_data = 5'($urandom);
      start_run(nv);
      ld_en = 1'b0;
      act = $urandom_range(0, 3);
      k = $urandom_range(0, 40);
      repeat (k) tick();
      if (act == 1) begin
        start = 1'b1; num_vec = 5'($urandom);
        ld_en = 1'b1; ld_addr = 4'($urandom); ld_data = 5'($urandom);
        tick();
        start = 1'b0; ld_en = 1'b0;
      end else if (act == 2) begin
        reset = 1'b1; tick(); reset = 1'b0; tick();
      end
      if (act != 2) wait_both();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
